// File: rtl/mc_request_queue.sv
// DDR5 controller request front end: in-order timestamped request FIFO with release delay.
// Optional MC_REQQ_ORDER_CHECK_EN builds the sticky timestamp-order checker.
module mc_request_queue #(
   parameter int DEPTH       = 16,
   parameter int TIME_W      = 32,
   parameter int ISSUE_DELAY = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_core,
   input  logic [TIME_W-1:0]        in_time,
   input  logic [1:0]               in_op,
   input  logic [33:0]              in_addr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3:0]               out_core,
   output logic [1:0]               out_op,
   output logic                     out_is_write,
   output logic [2:0]               out_bank_group,
   output logic [1:0]               out_bank,
   output logic                     out_channel,
   output logic [15:0]              out_row,
   output logic [9:0]               out_column,
   output logic [$clog2(DEPTH):0]   count,
   output logic [63:0]              cycle,
   output logic                     order_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [3:0]        mem_core [DEPTH];
   logic [TIME_W-1:0] mem_time [DEPTH];
   logic [1:0]        mem_op   [DEPTH];
   logic [33:0]       mem_addr [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          push;
   logic          pop;
   logic [63:0]   release_at;
   logic [33:0]   head_addr;
   logic [1:0]    head_op;

   // in_ready looks only at registered count, so a full queue never
   // accepts on the same edge it pops
   assign in_ready   = (count != CW'(DEPTH));
   assign push       = in_valid && in_ready;
   assign pop        = out_valid && out_ready;
   assign release_at = 64'(mem_time[head]) + 64'(ISSUE_DELAY);
   assign out_valid  = (count != '0) && (cycle >= release_at);
   assign head_addr  = mem_addr[head];
   assign head_op    = mem_op[head];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         cycle <= '0;
      end else begin
         cycle <= cycle + 64'd1;
         if (push)
            tail <= tail + PW'(1);
         if (pop)
            head <= head + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Entry storage needs no reset: count gates every read
   always_ff @(posedge clock) begin
      if (push) begin
         mem_core[tail] <= in_core;
         mem_time[tail] <= in_time;
         mem_op[tail]   <= in_op;
         mem_addr[tail] <= in_addr;
      end
   end

   always_comb begin
      out_core       = '0;
      out_op         = '0;
      out_is_write   = 1'b0;
      out_bank_group = '0;
      out_bank       = '0;
      out_channel    = 1'b0;
      out_row        = '0;
      out_column     = '0;
      if (count != '0) begin
         out_core       = mem_core[head];
         out_op         = head_op;
         out_is_write   = (head_op == 2'd1);
         out_bank_group = head_addr[9:7];
         out_bank       = head_addr[11:10];
         out_channel    = head_addr[6];
         out_row        = head_addr[33:18];
         out_column     = {head_addr[17:12], head_addr[5:2]};
      end
   end

`ifdef MC_REQQ_ORDER_CHECK_EN
   logic [TIME_W-1:0] prev_time;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prev_time <= '0;
         order_err <= 1'b0;
      end else if (push) begin
         if (in_time < prev_time)
            order_err <= 1'b1;
         prev_time <= in_time;
      end
   end
`else
   assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_mc_request_queue.sv
// Self-checking bench for mc_request_queue: queue-level reference model,
// per-cycle compare, directed literal checks and randomized traffic.
module tb_mc_request_queue;

   localparam int DEPTH       = 16;
   localparam int ISSUE_DELAY = 2;
`ifdef MC_REQQ_ORDER_CHECK_EN
   localparam bit ORDER_EN = 1'b1;
`else
   localparam bit ORDER_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_core;
   logic [31:0] in_time;
   logic [1:0]  in_op;
   logic [33:0] in_addr;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_core;
   logic [1:0]  out_op;
   logic        out_is_write;
   logic [2:0]  out_bank_group;
   logic [1:0]  out_bank;
   logic        out_channel;
   logic [15:0] out_row;
   logic [9:0]  out_column;
   logic [4:0]  count;
   logic [63:0] cycle;
   logic        order_err;

   always #5 clock = ~clock;

   mc_request_queue #(
      .DEPTH(DEPTH), .TIME_W(32), .ISSUE_DELAY(ISSUE_DELAY)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_core(in_core), .in_time(in_time),
      .in_op(in_op), .in_addr(in_addr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_core(out_core), .out_op(out_op),
      .out_is_write(out_is_write),
      .out_bank_group(out_bank_group), .out_bank(out_bank),
      .out_channel(out_channel), .out_row(out_row),
      .out_column(out_column), .count(count),
      .cycle(cycle), .order_err(order_err)
   );

   typedef struct {
      logic [3:0]  core;
      logic [31:0] t;
      logic [1:0]  op;
      logic [33:0] addr;
   } req_t;

   req_t            q[$];
   longint unsigned mcyc  = 0;
   bit              merr  = 1'b0;
   logic [31:0]     mprev = '0;
   int              n_pass  = 0;
   int              n_total = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   function automatic bit exp_valid();
      if (q.size() == 0) return 1'b0;
      return mcyc >= (64'(q[0].t) + 64'(ISSUE_DELAY));
   endfunction

   // Reference model: a plain FIFO of requests plus a cycle count
   always @(posedge clock or negedge reset_n) begin
      bit do_push;
      bit do_pop;
      if (!reset_n) begin
         q.delete();
         mcyc  = 0;
         merr  = 1'b0;
         mprev = '0;
      end else begin
         do_push = in_valid && (q.size() < DEPTH);
         do_pop  = exp_valid() && out_ready;
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            if (ORDER_EN && (in_time < mprev)) merr = 1'b1;
            mprev = in_time;
            q.push_back('{in_core, in_time, in_op, in_addr});
         end
         mcyc++;
      end
   end

   always @(negedge clock) begin
      logic [33:0] a;
      logic [3:0]  ec;
      logic [1:0]  eo;
      a  = '0;
      ec = '0;
      eo = '0;
      if (q.size() != 0) begin
         a  = q[0].addr;
         ec = q[0].core;
         eo = q[0].op;
      end
      check("count", 64'(count), 64'(q.size()));
      check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      check("out_valid", 64'(out_valid), 64'(exp_valid()));
      check("cycle", cycle, mcyc);
      check("order_err", 64'(order_err), 64'(merr));
      check("out_core", 64'(out_core), 64'(ec));
      check("out_op", 64'(out_op), 64'(eo));
      check("out_is_write", 64'(out_is_write), 64'(eo == 2'd1));
      check("out_bank_group", 64'(out_bank_group), 64'(a[9:7]));
      check("out_bank", 64'(out_bank), 64'(a[11:10]));
      check("out_channel", 64'(out_channel), 64'(a[6]));
      check("out_row", 64'(out_row), 64'(a[33:18]));
      check("out_column", 64'(out_column), 64'({a[17:12], a[5:2]}));
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic drive(input bit v, input logic [3:0] c,
                        input logic [31:0] t, input logic [1:0] o,
                        input logic [33:0] a);
      in_valid = v;
      in_core  = c;
      in_time  = t;
      in_op    = o;
      in_addr  = a;
   endtask

   task automatic wait_valid(input int lim, input string name);
      for (int n = 0; n < lim && !out_valid; n++) tick();
      check(name, 64'(out_valid), 64'd1);
   endtask

   task automatic drain(input string name);
      out_ready = 1'b1;
      for (int n = 0; n < 300 && count != 0; n++) tick();
      check(name, 64'(count), 64'd0);
      out_ready = 1'b0;
   endtask

   function automatic logic [33:0] rand_addr();
      return {2'($urandom_range(0, 3)), 32'($urandom)};
   endfunction

   initial begin
      logic [63:0] pc [2];
      logic [3:0]  pcore [2];
      int          np;
      logic [31:0] t;

      reset_n   = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, '0, '0, '0, '0);
      repeat (3) tick();
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_cycle", cycle, 64'd0);
      reset_n = 1'b1;

      // Basic release: push at cycle 1, time 10
      tick();
      out_ready = 1'b1;
      drive(1'b1, 4'd3, 32'd10, 2'd0, 34'h2_1234_5A7C);
      tick();
      drive(1'b0, '0, '0, '0, '0);
      wait_valid(40, "rel_wait");
      check("rel_cycle", cycle, 64'd12);
      check("rel_core", 64'(out_core), 64'd3);
      check("rel_bg", 64'(out_bank_group), 64'd4);
      check("rel_bank", 64'(out_bank), 64'd2);
      check("rel_row", 64'(out_row), 64'h848D);
      check("rel_col", 64'(out_column), 64'h05F);
      check("rel_chan", 64'(out_channel), 64'd1);
      tick();
      check("rel_popped", 64'(count), 64'd0);

      // Head blocking: time 500 then time 5
      drive(1'b1, 4'd1, 32'd500, 2'd0, rand_addr());
      tick();
      drive(1'b1, 4'd2, 32'd5, 2'd1, rand_addr());
      tick();
      drive(1'b0, '0, '0, '0, '0);
      np = 0;
      for (int n = 0; n < 700 && np < 2; n++) begin
         if (out_valid) begin
            pc[np]    = cycle;
            pcore[np] = out_core;
            np++;
         end
         tick();
      end
      check("blk_pops", 64'(np), 64'd2);
      check("blk_cyc0", pc[0], 64'd502);
      check("blk_core0", 64'(pcore[0]), 64'd1);
      check("blk_cyc1", pc[1], 64'd503);
      check("blk_core1", 64'(pcore[1]), 64'd2);

      // Fill and backpressure
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 4'(i), 32'd1000, 2'd2, rand_addr());
         tick();
      end
      drive(1'b0, '0, '0, '0, '0);
      check("full_count", 64'(count), 64'd16);
      check("full_ready", 64'(in_ready), 64'd0);
      drive(1'b1, 4'hF, 32'd1000, 2'd1, rand_addr());
      tick();
      drive(1'b0, '0, '0, '0, '0);
      check("full_17th", 64'(count), 64'd16);
      wait_valid(1200, "full_wait");
      check("full_rel_cycle", cycle, 64'd1002);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("full_ready_back", 64'(in_ready), 64'd1);
      check("full_count_15", 64'(count), 64'd15);
      drain("full_drain");

      // Simultaneous push/pop at count 5 across pointer wrap
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'(i), 32'(mcyc), 2'd0, rand_addr());
         tick();
      end
      drive(1'b0, '0, '0, '0, '0);
      repeat (3) tick();
      check("wrap_start", 64'(count), 64'd5);
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 4'(i + 5), 32'(mcyc), 2'($urandom_range(0, 3)), rand_addr());
         tick();
         check("wrap_count", 64'(count), 64'd5);
      end
      drive(1'b0, '0, '0, '0, '0);
      drain("wrap_drain");

      // Randomized traffic with periodic backpressure bursts
      for (int i = 0; i < 3000; i++) begin
         t = 32'(mcyc) + 32'($urandom_range(0, 8)) - 32'd4;
         drive($urandom_range(0, 99) < 55, 4'($urandom), t,
               2'($urandom_range(0, 3)), rand_addr());
         if (((i / 200) % 3) == 1)
            out_ready = ($urandom_range(0, 9) == 0);
         else
            out_ready = ($urandom_range(0, 99) < 70);
         tick();
      end
      drive(1'b0, '0, '0, '0, '0);
      drain("rand_drain");

      // Reset mid-run with 7 entries
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 4'(i), 32'(mcyc) + 32'd5000, 2'd0, rand_addr());
         tick();
      end
      drive(1'b0, '0, '0, '0, '0);
      check("mid_count7", 64'(count), 64'd7);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_cycle", cycle, 64'd0);
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      tick();
      reset_n = 1'b1;
      tick();
      drive(1'b1, 4'd9, 32'd0, 2'd1, rand_addr());
      tick();
      drive(1'b0, '0, '0, '0, '0);
      check("post_rst_count", 64'(count), 64'd1);
      wait_valid(10, "post_rst_wait");
      check("post_rst_core", 64'(out_core), 64'd9);
      check("post_rst_write", 64'(out_is_write), 64'd1);
      drain("post_rst_drain");

      // Timestamp order check: 20 then 15
      drive(1'b1, 4'd4, 32'd20, 2'd0, rand_addr());
      tick();
      check("ord_first", 64'(order_err), 64'd0);
      drive(1'b1, 4'd5, 32'd15, 2'd0, rand_addr());
      tick();
      drive(1'b0, '0, '0, '0, '0);
      check("ord_set", 64'(order_err), 64'(ORDER_EN));
      repeat (5) tick();
      check("ord_sticky", 64'(order_err), 64'(ORDER_EN));
      drain("ord_drain");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
